// File: rtl/trace_request_fifo.sv
// Purpose: buffers pushed trace elements and their IF end times, and serves one per consumer request episode.
// Latency: a request sampled while non-empty gives data_valid on the next cycle; a push is poppable one edge later.
// Backpressure: none upstream. A push into a full FIFO with no pop that cycle is dropped and counted.
module trace_request_fifo #(
    parameter int DEPTH       = 16,
    parameter int TRACE_WIDTH = 128,
    parameter int TIME_WIDTH  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ready_signal,
    input  logic [TRACE_WIDTH-1:0]   trace_element_in,
    input  logic [TIME_WIDTH-1:0]    if_stage_end_in,
    input  logic                     data_request,
    output logic                     data_present,
    output logic                     data_valid,
    output logic [TRACE_WIDTH-1:0]   trace_element_out,
    output logic [TIME_WIDTH-1:0]    if_stage_end_out,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     overflow,
    output logic [15:0]              drop_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SERVE     = 2'd1,
        WAIT_DROP = 2'd2
    } state_t;

    state_t                 state;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic [TRACE_WIDTH-1:0] mem_trace [DEPTH];
    logic [TIME_WIDTH-1:0]  mem_time  [DEPTH];

    logic pop;
    logic push;
    logic drop;

    // Pop only from IDLE with data; a pop frees a slot so a same-cycle push at full is accepted.
    always_comb begin
        pop  = 1'b0;
        push = 1'b0;
        drop = 1'b0;
        pop  = (state == IDLE) && data_request && (count != '0);
        push = ready_signal && ((count != FULL) || pop);
        drop = ready_signal && !push;
    end

    assign data_present = (count != '0);
    assign occupancy    = count;

    // Element storage; no reset needed since pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_trace[wr_ptr] <= trace_element_in;
            mem_time[wr_ptr]  <= if_stage_end_in;
        end
    end

    // Pointers, occupancy and drop accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end
        end
    end

    // Serve FSM: one pop per request episode, data_valid is a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            data_valid        <= 1'b0;
            trace_element_out <= '0;
            if_stage_end_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    data_valid <= 1'b0;
                    if (pop) begin
                        trace_element_out <= mem_trace[rd_ptr];
                        if_stage_end_out  <= mem_time[rd_ptr];
                        data_valid        <= 1'b1;
                        state             <= SERVE;
                    end
                end
                SERVE: begin
                    data_valid <= 1'b0;
                    state      <= data_request ? WAIT_DROP : IDLE;
                end
                WAIT_DROP: begin
                    data_valid <= 1'b0;
                    if (!data_request) state <= IDLE;
                end
                default: begin
                    data_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trace_request_fifo.sv
module tb_trace_request_fifo;

    localparam int DEPTH = 16;
    localparam int TW    = 128;
    localparam int MW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          ready_signal;
    logic [TW-1:0] trace_element_in;
    logic [MW-1:0] if_stage_end_in;
    logic          data_request;
    logic          data_present;
    logic          data_valid;
    logic [TW-1:0] trace_element_out;
    logic [MW-1:0] if_stage_end_out;
    logic [4:0]    occupancy;
    logic          overflow;
    logic [15:0]   drop_count;

    trace_request_fifo #(.DEPTH(DEPTH), .TRACE_WIDTH(TW), .TIME_WIDTH(MW)) dut (
        .clk(clk), .rst(rst), .ready_signal(ready_signal),
        .trace_element_in(trace_element_in), .if_stage_end_in(if_stage_end_in),
        .data_request(data_request), .data_present(data_present), .data_valid(data_valid),
        .trace_element_out(trace_element_out), .if_stage_end_out(if_stage_end_out),
        .occupancy(occupancy), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TW-1:0] t;
        logic [MW-1:0] e;
    } ent_t;

    // Reference model: queue contents, last served element, and the
    // "one element per request episode" rule (an episode ends when request is seen low).
    ent_t q[$];
    ent_t last_out;
    bit   episode_served;
    bit   exp_ovf;
    int   exp_drops;
    bit   exp_dv;
    int   vectors;
    int   miscompares;
    int   dv_pulses;

    task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply the currently driven inputs across one clock edge and compare all outputs.
    task automatic cycle();
        bit pop;
        bit accept;
        pop = 1'b0;
        if (rst) begin
            q.delete();
            episode_served = 1'b0;
            exp_ovf        = 1'b0;
            exp_drops      = 0;
            last_out       = '0;
        end else begin
            pop    = data_request && !episode_served && (q.size() > 0);
            accept = ready_signal && ((q.size() < DEPTH) || pop);
            if (pop) begin
                last_out       = q.pop_front();
                episode_served = 1'b1;
            end else if (!data_request) begin
                episode_served = 1'b0;
            end
            if (accept) q.push_back({trace_element_in, if_stage_end_in});
            else if (ready_signal) begin
                exp_ovf = 1'b1;
                if (exp_drops < 65535) exp_drops++;
            end
        end
        exp_dv = pop;
        @(posedge clk);
        #1;
        if (data_valid) dv_pulses++;
        check("data_valid",   TW'(data_valid),        TW'(exp_dv));
        check("trace_out",    trace_element_out,      last_out.t);
        check("time_out",     TW'(if_stage_end_out),  TW'(last_out.e));
        check("occupancy",    TW'(occupancy),         TW'(q.size()));
        check("data_present", TW'(data_present),      TW'(q.size() != 0));
        check("overflow",     TW'(overflow),          TW'(exp_ovf));
        check("drop_count",   TW'(drop_count),        TW'(exp_drops));
    endtask

    task automatic idle_inputs();
        ready_signal     = 1'b0;
        data_request     = 1'b0;
        trace_element_in = '0;
        if_stage_end_in  = '0;
    endtask

    task automatic push_one(input logic [TW-1:0] t, input logic [MW-1:0] e);
        ready_signal     = 1'b1;
        trace_element_in = t;
        if_stage_end_in  = e;
        cycle();
        ready_signal     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        cycle();
        rst = 1'b0;
    endtask

    // Consumer in the validity-filter style: hold request until data_valid, then drop it.
    task automatic read_one(input string tag);
        bit seen;
        seen = 1'b0;
        data_request = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            seen = data_valid;
        end
        check(tag, TW'(seen), TW'(1));
        data_request = 1'b0;
        cycle();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        dv_pulses   = 0;
        rst         = 1'b1;
        idle_inputs();

        // Reset state and three pushes.
        do_reset();
        push_one(128'hA, 32'd10);
        push_one(128'hB, 32'd11);
        push_one(128'hC, 32'd12);
        check("t1_occ",     TW'(occupancy),    TW'(3));
        check("t1_present", TW'(data_present), TW'(1));

        // Three request episodes drain A, B, C in order.
        read_one("t2_dv_a");
        check("t2_out_a", trace_element_out, 128'hA);
        read_one("t2_dv_b");
        read_one("t2_dv_c");
        check("t2_time_c",  TW'(if_stage_end_out), TW'(12));
        check("t2_present", TW'(data_present),     TW'(0));

        // Long-held request with two entries yields exactly one pulse.
        push_one(128'h1111, 32'd20);
        push_one(128'h2222, 32'd21);
        dv_pulses    = 0;
        data_request = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
        data_request = 1'b0;
        cycle();
        check("t3_pulses", TW'(dv_pulses), TW'(1));
        check("t3_occ",    TW'(occupancy), TW'(1));

        // Overfill with no reads, then drain in order.
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) push_one(TW'(i + 100), MW'(i + 500));
        check("t4_occ",   TW'(occupancy),  TW'(DEPTH));
        check("t4_ovf",   TW'(overflow),   TW'(1));
        check("t4_drops", TW'(drop_count), TW'(2));
        for (int i = 0; i < DEPTH; i++) read_one("t4_dv");
        check("t4_last", trace_element_out, TW'(DEPTH - 1 + 100));

        // Push+pop at full, repeated long enough to wrap both pointers twice.
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_one(TW'(i + 1000), MW'(i));
        for (int i = 0; i < 2 * DEPTH; i++) begin
            data_request     = 1'b1;
            ready_signal     = 1'b1;
            trace_element_in = {$urandom, $urandom, $urandom, $urandom};
            if_stage_end_in  = $urandom;
            cycle();
            idle_inputs();
            cycle();
        end
        check("t5_occ",   TW'(occupancy),  TW'(DEPTH));
        check("t5_drops", TW'(drop_count), TW'(0));

        // Reset during the serve cycle aborts everything.
        data_request = 1'b1;
        cycle();
        check("t6_dv_before", TW'(data_valid), TW'(1));
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        data_request = 1'b0;
        check("t6_dv",   TW'(data_valid),   TW'(0));
        check("t6_occ",  TW'(occupancy),    TW'(0));
        check("t6_pres", TW'(data_present), TW'(0));
        cycle();

        // Randomized traffic with occasional request toggling and bursts of pushes.
        for (int i = 0; i < 2000; i++) begin
            ready_signal     = ($urandom_range(0, 99) < 55);
            data_request     = ($urandom_range(0, 99) < 45);
            trace_element_in = {$urandom, $urandom, $urandom, $urandom};
            if_stage_end_in  = $urandom;
            rst              = ($urandom_range(0, 999) == 0);
            cycle();
        end
        rst = 1'b0;
        idle_inputs();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
